// File: rtl/spi_register_bridge.sv
// SPI (mode 0) slave that turns 32-bit frames into register writes for the synth core.
// Frame = {register number[15:0], register value[15:0]}; MISO returns {frame count, error count}.
`timescale 1ns/1ps
module spi_register_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SpiClock,
    input  logic        i_SpiChipSelect_n,
    input  logic        i_SpiMosi,
    output logic        o_SpiMiso,
    output logic [15:0] o_RegisterNumber,
    output logic [15:0] o_RegisterValue,
    output logic        o_RegisterWriteEnable,
    output logic        o_FrameError
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int FILL_DEPTH = SYNC_STAGES + 1;

    function automatic logic [5:0] bit_cnt_inc(input logic [5:0] cnt);
        return (cnt >= 6'd33) ? 6'd33 : cnt + 6'd1;
    endfunction

    function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    state_t      state;
    state_t      state_next;
    logic [2:0]  fill_cnt;
    logic        armed;
    logic        start_pend;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [15:0] status_sh;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic filled;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic frame_err;

    // Input synchronizers plus one history flop for edge detection
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SpiClock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SpiChipSelect_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SpiMosi};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Reset values in the pipe are not real pin samples; a frame may only start once
    // CS_n has genuinely been observed high, so a CS_n held low through reset is ignored.
    assign filled    = (fill_cnt == 3'(FILL_DEPTH));
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_rise   = filled & cs_s & ~cs_hist;
    assign cs_fall   = armed & ~cs_s & cs_hist;

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        frame_err             = 1'b0;
        o_RegisterWriteEnable = 1'b0;
        o_SpiMiso             = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall || start_pend) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                o_SpiMiso = status_sh[15];
                if (cs_rise) begin
                    if (bit_cnt == 6'd32) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = IDLE;
                        frame_err  = 1'b1;
                    end
                end
            end
            COMMIT: begin
                o_RegisterWriteEnable = 1'b1;
                state_next            = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath, counters and registered outputs
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            fill_cnt         <= '0;
            armed            <= 1'b0;
            start_pend       <= 1'b0;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            status_sh        <= '0;
            frame_cnt        <= '0;
            err_cnt          <= '0;
            o_RegisterNumber <= '0;
            o_RegisterValue  <= '0;
            o_FrameError     <= 1'b0;
        end else begin
            o_FrameError <= frame_err;
            start_pend   <= (state == COMMIT) && cs_fall;
            if (!filled) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
            if (filled && cs_s && cs_hist) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (state_next == SHIFT) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        status_sh <= {frame_cnt, err_cnt};
                    end
                end
                SHIFT: begin
                    // A CS_n rise in the same cycle as an SCLK edge ends the frame first
                    if (cs_rise) begin
                        if (bit_cnt == 6'd32) begin
                            o_RegisterNumber <= shift_reg[31:16];
                            o_RegisterValue  <= shift_reg[15:0];
                        end else begin
                            err_cnt <= err_cnt_inc(err_cnt);
                        end
                    end else begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[30:0], mosi_s};
                            bit_cnt   <= bit_cnt_inc(bit_cnt);
                        end
                        if (sclk_fall) begin
                            status_sh <= {status_sh[14:0], 1'b0};
                        end
                    end
                end
                COMMIT: begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Scoreboard bench for spi_register_bridge: directed SPI frames, expected writes and
// frame errors queued by the stimulus, popped and compared by a strobe monitor.
`timescale 1ns/1ps
module tb_spi_register_bridge;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [15:0] reg_num;
    logic [15:0] reg_val;
    logic        reg_we;
    logic        frame_err;

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          cs_rise_cyc;
    bit          lat_req;
    logic [31:0] exp_wr[$];
    int          exp_err[$];
    logic [31:0] exp_word;
    int          dummy;

    spi_register_bridge #(.SYNC_STAGES(SYNC)) dut (
        .i_Clock              (clk),
        .i_Reset_n            (rst_n),
        .i_SpiClock           (sclk),
        .i_SpiChipSelect_n    (cs_n),
        .i_SpiMosi            (mosi),
        .o_SpiMiso            (miso),
        .o_RegisterNumber     (reg_num),
        .o_RegisterValue      (reg_val),
        .o_RegisterWriteEnable(reg_we),
        .o_FrameError         (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) begin
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h, expected no write", {reg_num, reg_val});
                end else begin
                    exp_word = exp_wr.pop_front();
                    check("write_data", {reg_num, reg_val}, exp_word);
                end
                if (lat_req) begin
                    lat_req = 1'b0;
                    check("write_latency_in_window",
                          32'((cyc - cs_rise_cyc >= SYNC + 1) && (cyc - cs_rise_cyc <= SYNC + 2)), 32'd1);
                end
            end
            if (frame_err) begin
                if (exp_err.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame_error: got 1, expected 0");
                end else begin
                    dummy = exp_err.pop_front();
                    check("frame_error", 32'(frame_err), 32'd1);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input bit cs_up, output logic m);
        mosi = b;
        repeat (4) @(negedge clk);
        m    = miso;
        sclk = 1'b1;
        if (cs_up) cs_n = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [63:0] data, input int nbits, input bit cs_with_last,
                             output logic [31:0] mw);
        logic m;
        mw   = '0;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[nbits-1-i], cs_with_last && (i == nbits - 1), m);
            if (i < 32) mw[31-i] = m;
        end
        if (!cs_with_last) begin
            repeat (4) @(negedge clk);
            cs_n        = 1'b1;
            cs_rise_cyc = cyc;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #950000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mw;
        logic        m;
        n_chk   = 0;
        n_fail  = 0;
        lat_req = 1'b0;
        rst_n   = 1'b0;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_number", 32'(reg_num), 32'h0);
        check("rst_value", 32'(reg_val), 32'h0);
        check("rst_we", 32'(reg_we), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // 31-bit then 33-bit frame: two errors, no write
        exp_err.push_back(1);
        spi_frame(64'h0803_1234, 31, 1'b0, mw);
        check("status_first", 32'(mw[31:16]), 32'h0000);
        exp_err.push_back(1);
        spi_frame(64'h1_0803_1234, 33, 1'b0, mw);
        check("status_after_err", 32'(mw[31:16]), 32'h0001);
        check("held_after_errs", {reg_num, reg_val}, 32'h0);

        // Valid frame with latency check
        exp_wr.push_back(32'h0803_1234);
        lat_req = 1'b1;
        spi_frame(64'h0803_1234, 32, 1'b0, mw);
        check("status_two_errs", 32'(mw[31:16]), 32'h0002);
        check("held_after_write", {reg_num, reg_val}, 32'h0803_1234);
        check("latency_seen", 32'(lat_req), 32'h0);

        // Three frames, fourth reads status then zeros
        do_reset();
        exp_wr.push_back(32'hA5A5_0001);
        spi_frame(64'hA5A5_0001, 32, 1'b0, mw);
        exp_wr.push_back(32'h5A5A_FFFE);
        spi_frame(64'h5A5A_FFFE, 32, 1'b0, mw);
        exp_wr.push_back(32'h0001_8000);
        spi_frame(64'h0001_8000, 32, 1'b0, mw);
        exp_wr.push_back(32'h7FFF_C3C3);
        spi_frame(64'h7FFF_C3C3, 32, 1'b0, mw);
        check("miso_fourth_frame", mw, 32'h0300_0000);

        // CS and SCLK rise together on bit 32: counted as 31 bits
        exp_err.push_back(1);
        spi_frame(64'h1111_2222, 32, 1'b1, mw);
        check("status_fifth", 32'(mw[31:16]), 32'h0400);
        check("held_after_collision", {reg_num, reg_val}, 32'h7FFF_C3C3);

        // Reset after 20 bits, CS held low through release, then a valid frame
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0, m);
        rst_n = 1'b0;
        #1;
        check("async_rst_number", 32'(reg_num), 32'h0);
        check("async_rst_value", 32'(reg_val), 32'h0);
        check("async_rst_miso", 32'(miso), 32'h0);
        check("async_rst_we_ferr", {30'h0, reg_we, frame_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0, m);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_frame_before_cs_high", {reg_num, reg_val}, 32'h0);
        exp_wr.push_back(32'h0100_0001);
        spi_frame(64'h0100_0001, 32, 1'b0, mw);
        check("status_after_abort", 32'(mw[31:16]), 32'h0000);

        // 256 frames wrap the frame count
        do_reset();
        for (int i = 0; i < 256; i++) begin
            exp_word = {16'(i), ~16'(i)};
            exp_wr.push_back(exp_word);
            spi_frame({32'h0, exp_word}, 32, 1'b0, mw);
        end
        exp_wr.push_back(32'hBEEF_0042);
        spi_frame(64'hBEEF_0042, 32, 1'b0, mw);
        check("miso_after_wrap", mw, 32'h0000_0000);

        repeat (20) @(negedge clk);
        check("writes_outstanding", 32'(exp_wr.size()), 32'h0);
        check("errors_outstanding", 32'(exp_err.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_register_bridge.md
SPI_REGISTER_BRIDGE -- requirements
Module: spi_register_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flip-flop depth on i_SpiClock, i_SpiChipSelect_n and i_SpiMosi; legal range 2..4.
REQ-002 SHALL have port i_Clock, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_SpiClock, input, 1: SPI SCLK, mode 0, asynchronous to i_Clock.
REQ-005 SHALL have port i_SpiChipSelect_n, input, 1: SPI chip select, active-low.
REQ-006 SHALL have port i_SpiMosi, input, 1: serial data in, MSB first.
REQ-007 SHALL have port o_SpiMiso, output, 1: serial status out, MSB first.
REQ-008 SHALL have port o_RegisterNumber, output, 16: address of the last committed frame; feeds synth i_RegisterNumber.
REQ-009 SHALL have port o_RegisterValue, output, 16: data of the last committed frame; feeds synth i_RegisterValue.
REQ-010 SHALL have port o_RegisterWriteEnable, output, 1: one-cycle commit strobe; feeds synth i_RegisterWriteEnable.
REQ-011 SHALL have port o_FrameError, output, 1: one-cycle strobe when a frame is discarded.

Function
REQ-012 SHALL pass each SPI input through SYNC_STAGES flops, plus one history flop for edge detection; an SCLK edge is seen SYNC_STAGES+1 i_Clock cycles after the pin toggles.
REQ-013 Supported SCLK frequency SHALL be at most i_Clock/8, with high and low phases each at least 4 i_Clock cycles.
REQ-014 SHALL use a state machine with three states: IDLE, SHIFT, COMMIT.
REQ-015 IDLE -> SHIFT SHALL occur on a synced CS_n falling edge; on entry, bit counter = 0, shift register = 0, status word loaded.
REQ-016 In SHIFT, each synced SCLK rising edge SHALL shift synced MOSI into the LSB of a 32-bit shift register and increment the 6-bit bit counter, saturating at 33.
REQ-017 Frame format SHALL be bits[31:16] = register number and bits[15:0] = register value.
REQ-018 SHALL transition SHIFT -> COMMIT on a synced CS_n rising edge if the bit counter equals 32, otherwise SHIFT -> IDLE.
REQ-019 On the SHIFT -> IDLE (wrong count) transition, o_FrameError SHALL pulse for 1 cycle, the error count SHALL increment (saturating at 255), and the outputs SHALL be unchanged.
REQ-020 In COMMIT (1 cycle), the design SHALL load o_RegisterNumber/o_RegisterValue, pulse o_RegisterWriteEnable high for exactly that cycle, increment the 8-bit frame count (wraps 255 -> 0), then go to IDLE.
REQ-021 o_RegisterNumber/o_RegisterValue SHALL be stable at the strobe and held until the next commit.
REQ-022 If a CS_n rising edge and an SCLK rising edge are detected in the same cycle, the CS edge SHALL win and the SCLK edge SHALL be ignored.
REQ-023 SCLK edges SHALL be ignored in IDLE and COMMIT.
REQ-024 A CS_n falling edge detected during COMMIT SHALL be honoured on the following cycle (IDLE -> SHIFT).
REQ-025 Status word = {frame count[7:0], error count[7:0]}, latched at frame start.
REQ-026 MISO behaviour:
  - Bit 15 of the status word SHALL drive o_SpiMiso on SHIFT entry.
  - Each subsequent synced SCLK falling edge in SHIFT SHALL advance one bit.
  - After 16 bits, o_SpiMiso SHALL be 0.
  - Outside SHIFT, o_SpiMiso SHALL be 0.
REQ-027 No arithmetic SHALL exceed its stated width; all counters SHALL be unsigned.

Reset
REQ-028 On i_Reset_n low, all of the following SHALL clear immediately, regardless of i_Clock:
  - State -> IDLE.
  - Synchronizers: CS_n stages = 1, SCLK and MOSI stages = 0.
  - o_RegisterNumber = 0, o_RegisterValue = 0.
  - o_RegisterWriteEnable = 0, o_FrameError = 0, o_SpiMiso = 0.
  - Frame count = 0, error count = 0, bit counter = 0, shift register = 0.
REQ-029 Reset SHALL be released synchronously via the system reset synchronizer (outside this block).
REQ-030 Reset asserted mid-frame SHALL abort the frame with no write strobe and no error strobe.
REQ-031 If CS_n is already low when reset releases, the block SHALL wait for a full CS_n high-then-low before accepting a frame.

Verification
REQ-032 Frame 0x0803_1234, 32 clocks at i_Clock/8 -> exactly one write strobe with number 0x0803 and value 0x1234, SYNC_STAGES+2 cycles after the CS_n pin rises.
REQ-033 A 31-bit frame, then a 33-bit frame -> two o_FrameError pulses, no write strobe, outputs unchanged, next status word 0x0002.
REQ-034 Three valid frames, then a fourth frame -> MISO reads 0x0300 on the first 16 bits, then 0 for the remaining 16.
REQ-035 Reset pulse after 20 bits of a frame, then a valid frame 0x0100_0001 -> exactly one strobe, carrying 0x0100/0x0001.
REQ-036 256 valid frames -> frame count wraps to 0, so the status word is 0x0000.
REQ-037 CS_n pin rising and SCLK pin rising in the same cycle on bit 32 -> frame treated as 31 bits, o_FrameError pulses, no strobe.
